ipf_job_ctrl: RTL and testbench



---
 rtl/ipf_job_ctrl.sv | 158 +++++++++++++++
 tb/tb_ipf_job_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipf_job_ctrl.sv
//------------------------------------------------------------------------------
// ipf_job_ctrl : job sequencer for the image post-filter engine
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ipf_job_ctrl #(
  parameter int Addr_Width   = 16,
  parameter int Expect_Pix   = 64516,
  parameter int Clr_Cycles   = 2,
  parameter int Drain_Cycles = 3,
  parameter int Tmo_Width    = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_mode,
  output logic                  cmd_ready,
  output logic                  ipf_rst,
  output logic [1:0]            ipf_mode,
  output logic                  ipf_gray_ready,
  input  logic                  ipf_valid,
  input  logic                  ipf_finish,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [1:0]            done_status,
  output logic [Addr_Width:0]   done_pix_cnt,
  output logic                  busy
);

  localparam int c_PW = Addr_Width + 1;
  localparam int c_CW = 16;

  localparam logic [1:0] c_ST_OK       = 2'b00;
  localparam logic [1:0] c_ST_MISMATCH = 2'b01;
  localparam logic [1:0] c_ST_BADMODE  = 2'b10;
  localparam logic [1:0] c_ST_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_mode, w_mode_nxt;
  logic [1:0]            r_status, w_status_nxt;
  logic [c_PW-1:0]       r_pix_cnt, w_pix_nxt;
  logic [Tmo_Width-1:0]  r_wdog, w_wdog_nxt;
  logic [c_CW-1:0]       r_phase, w_phase_nxt;

  logic [c_PW-1:0]       w_pix_inc;
  logic [c_PW-1:0]       w_pix_counted;

  // Saturating increment so an overrun job still reports a mismatch
  assign w_pix_inc     = (r_pix_cnt == '1) ? r_pix_cnt : r_pix_cnt + c_PW'(1);
  assign w_pix_counted = ipf_valid ? w_pix_inc : r_pix_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= 2'b00;
      r_status  <= c_ST_OK;
      r_pix_cnt <= '0;
      r_wdog    <= '0;
      r_phase   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_status  <= w_status_nxt;
      r_pix_cnt <= w_pix_nxt;
      r_wdog    <= w_wdog_nxt;
      r_phase   <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_status_nxt = r_status;
    w_pix_nxt    = r_pix_cnt;
    w_wdog_nxt   = r_wdog;
    w_phase_nxt  = r_phase;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_pix_nxt = '0;
          if (cmd_mode == 2'd3) begin
            w_status_nxt = c_ST_BADMODE;
            w_state_nxt  = S_REPORT;
          end else begin
            w_mode_nxt  = cmd_mode;
            w_wdog_nxt  = '0;
            w_phase_nxt = '0;
            w_state_nxt = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        if (r_phase == c_CW'(Clr_Cycles - 1)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_phase_nxt = r_phase + c_CW'(1);
        end
      end

      S_RUN: begin
        w_pix_nxt  = w_pix_counted;
        w_wdog_nxt = ipf_valid ? '0 : r_wdog + Tmo_Width'(1);
        // Finish takes priority over a coincident watchdog expiry
        if (ipf_finish) begin
          w_phase_nxt = '0;
          w_state_nxt = S_DRAIN;
        end else if (r_wdog == '1) begin
          w_status_nxt = c_ST_TIMEOUT;
          w_state_nxt  = S_REPORT;
        end
      end

      S_DRAIN: begin
        w_pix_nxt = w_pix_counted;
        if (r_phase == c_CW'(Drain_Cycles - 1)) begin
          w_status_nxt = (w_pix_counted == c_PW'(Expect_Pix)) ? c_ST_OK : c_ST_MISMATCH;
          w_state_nxt  = S_REPORT;
        end else begin
          w_phase_nxt = r_phase + c_CW'(1);
        end
      end

      S_REPORT: begin
        if (done_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs: ipf_rst follows the async-reset state immediately
  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign ipf_rst        = (r_state == S_IDLE) || (r_state == S_CLEAR) || (r_state == S_REPORT);
  assign ipf_gray_ready = (r_state == S_RUN);
  assign done_valid     = (r_state == S_REPORT);
  assign ipf_mode       = r_mode;
  assign done_status    = r_status;
  assign done_pix_cnt   = r_pix_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ipf_job_ctrl.sv
//------------------------------------------------------------------------------
// tb_ipf_job_ctrl : directed self-checking bench for ipf_job_ctrl
// Revision        : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ipf_job_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_mode;
  logic        cmd_ready;
  logic        ipf_rst;
  logic [1:0]  ipf_mode;
  logic        ipf_gray_ready;
  logic        ipf_valid;
  logic        ipf_finish;
  logic        done_valid;
  logic        done_ready;
  logic [1:0]  done_status;
  logic [16:0] done_pix_cnt;
  logic        busy;

  // {cmd_ready, busy, ipf_rst, ipf_gray_ready, done_valid}
  logic [4:0]  ctl;
  assign ctl = {cmd_ready, busy, ipf_rst, ipf_gray_ready, done_valid};

  int errors = 0;
  int checks = 0;

  ipf_job_ctrl #(
    .Addr_Width   (16),
    .Expect_Pix   (4),
    .Clr_Cycles   (2),
    .Drain_Cycles (3),
    .Tmo_Width    (4)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_mode       (cmd_mode),
    .cmd_ready      (cmd_ready),
    .ipf_rst        (ipf_rst),
    .ipf_mode       (ipf_mode),
    .ipf_gray_ready (ipf_gray_ready),
    .ipf_valid      (ipf_valid),
    .ipf_finish     (ipf_finish),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .done_status    (done_status),
    .done_pix_cnt   (done_pix_cnt),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0;
    ipf_valid = 1'b0; ipf_finish = 1'b0; done_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b10100) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, 5'b10100); end
    checks++;
    if (done_pix_cnt !== 17'd0 || done_status !== 2'b00 || ipf_mode !== 2'b00) begin
      errors++; $display("FAIL reset_data: got cnt=%0d st=%b mode=%0d want 0/00/0", done_pix_cnt, done_status, ipf_mode);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (ctl !== 5'b10100) begin errors++; $display("FAIL reset_release_ctl: got %b want %b", ctl, 5'b10100); end
  endtask

  task automatic test_normal_job();
    cmd_valid = 1'b1; cmd_mode = 2'd1;
    checks++;
    if (ctl !== 5'b10100) begin errors++; $display("FAIL normal_accept_ctl: got %b want %b", ctl, 5'b10100); end
    step();                                    // +1 CLEAR
    cmd_valid = 1'b0; cmd_mode = 2'd3;         // ignored outside IDLE
    checks++;
    if (ctl !== 5'b01100 || ipf_mode !== 2'd1) begin
      errors++; $display("FAIL normal_clear1: got ctl=%b mode=%0d want 01100/1", ctl, ipf_mode);
    end
    step();                                    // +2 CLEAR
    checks++;
    if (ctl !== 5'b01100) begin errors++; $display("FAIL normal_clear2: got %b want %b", ctl, 5'b01100); end
    step();                                    // +3 RUN
    checks++;
    if (ctl !== 5'b01010 || ipf_mode !== 2'd1) begin
      errors++; $display("FAIL normal_run_entry: got ctl=%b mode=%0d want 01010/1", ctl, ipf_mode);
    end
    ipf_valid = 1'b1;
    step(); step();                            // +4, +5
    step();                                    // +6: finish cycle
    ipf_valid = 1'b0; ipf_finish = 1'b1;
    checks++;
    if (done_pix_cnt !== 17'd3) begin errors++; $display("FAIL normal_run_cnt: got %0d want 3", done_pix_cnt); end
    step();                                    // +7 DRAIN
    ipf_finish = 1'b0; ipf_valid = 1'b1;
    checks++;
    if (ctl !== 5'b01000 || ipf_mode !== 2'd1) begin
      errors++; $display("FAIL normal_drain: got ctl=%b mode=%0d want 01000/1", ctl, ipf_mode);
    end
    step();                                    // +8
    ipf_valid = 1'b0;
    step();                                    // +9
    checks++;
    if (ctl !== 5'b01000 || done_pix_cnt !== 17'd4) begin
      errors++; $display("FAIL normal_drain_end: got ctl=%b cnt=%0d want 01000/4", ctl, done_pix_cnt);
    end
    step();                                    // +10 REPORT
    checks++;
    if (ctl !== 5'b01101 || done_status !== 2'b00 || done_pix_cnt !== 17'd4 || ipf_mode !== 2'd1) begin
      errors++; $display("FAIL normal_report: got ctl=%b st=%b cnt=%0d mode=%0d want 01101/00/4/1",
                         ctl, done_status, done_pix_cnt, ipf_mode);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0; cmd_mode = 2'd0;
    checks++;
    if (ctl !== 5'b10100) begin errors++; $display("FAIL normal_handshake: got %b want %b", ctl, 5'b10100); end
  endtask

  task automatic test_mismatch();
    cmd_valid = 1'b1; cmd_mode = 2'd2;
    step();                                    // +1
    cmd_valid = 1'b0;
    step(); step();                            // +3 RUN
    ipf_valid = 1'b1;
    step();                                    // +4
    step();                                    // +5 finish
    ipf_valid = 1'b0; ipf_finish = 1'b1;
    step();                                    // +6 DRAIN
    ipf_finish = 1'b0;
    step(); step();                            // +8
    checks++;
    if (ctl !== 5'b01000) begin errors++; $display("FAIL mismatch_drain: got %b want %b", ctl, 5'b01000); end
    step();                                    // +9 REPORT
    checks++;
    if (ctl !== 5'b01101 || done_status !== 2'b01 || done_pix_cnt !== 17'd2 || ipf_mode !== 2'd2) begin
      errors++; $display("FAIL mismatch_report: got ctl=%b st=%b cnt=%0d mode=%0d want 01101/01/2/2",
                         ctl, done_status, done_pix_cnt, ipf_mode);
    end
    ipf_valid = 1'b1;                          // ignored in REPORT
    step();
    checks++;
    if (done_pix_cnt !== 17'd2 || done_status !== 2'b01) begin
      errors++; $display("FAIL mismatch_report_hold: got cnt=%0d st=%b want 2/01", done_pix_cnt, done_status);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    step();                                    // IDLE with ipf_valid still high
    ipf_valid = 1'b0;
    checks++;
    if (ctl !== 5'b10100 || done_pix_cnt !== 17'd2) begin
      errors++; $display("FAIL mismatch_idle_ignore: got ctl=%b cnt=%0d want 10100/2", ctl, done_pix_cnt);
    end
  endtask

  task automatic test_illegal_backpressure();
    cmd_valid = 1'b1; cmd_mode = 2'd3;
    step();                                    // +1 REPORT
    cmd_valid = 1'b0; cmd_mode = 2'd0;
    checks++;
    if (ctl !== 5'b01101 || done_status !== 2'b10 || done_pix_cnt !== 17'd0 || ipf_mode !== 2'd2) begin
      errors++; $display("FAIL illegal_report: got ctl=%b st=%b cnt=%0d mode=%0d want 01101/10/0/2",
                         ctl, done_status, done_pix_cnt, ipf_mode);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (ctl !== 5'b01101 || done_status !== 2'b10 || done_pix_cnt !== 17'd0) begin
        errors++; $display("FAIL backpressure_hold[%0d]: got ctl=%b st=%b cnt=%0d want 01101/10/0",
                           i, ctl, done_status, done_pix_cnt);
      end
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    checks++;
    if (ctl !== 5'b10100) begin errors++; $display("FAIL illegal_handshake: got %b want %b", ctl, 5'b10100); end
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_mode = 2'd0;
    step();                                    // +1
    cmd_valid = 1'b0;
    for (int i = 2; i <= 18; i++) begin
      step();
      if (i >= 3) begin
        checks++;
        if (ctl !== 5'b01010) begin errors++; $display("FAIL timeout_run[+%0d]: got %b want %b", i, ctl, 5'b01010); end
      end
    end
    step();                                    // +19 REPORT
    checks++;
    if (ctl !== 5'b01101 || done_status !== 2'b11 || done_pix_cnt !== 17'd0 || ipf_mode !== 2'd0) begin
      errors++; $display("FAIL timeout_report: got ctl=%b st=%b cnt=%0d mode=%0d want 01101/11/0/0",
                         ctl, done_status, done_pix_cnt, ipf_mode);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_finish_at_expiry();
    cmd_valid = 1'b1; cmd_mode = 2'd1;
    step();                                    // +1
    cmd_valid = 1'b0;
    for (int i = 2; i <= 18; i++) step();      // +18: watchdog at all-ones
    ipf_finish = 1'b1;
    step();                                    // +19 DRAIN
    ipf_finish = 1'b0;
    checks++;
    if (ctl !== 5'b01000) begin errors++; $display("FAIL expiry_finish_drain: got %b want %b", ctl, 5'b01000); end
    step(); step();                            // +21
    checks++;
    if (ctl !== 5'b01000) begin errors++; $display("FAIL expiry_finish_drain_end: got %b want %b", ctl, 5'b01000); end
    step();                                    // +22 REPORT
    checks++;
    if (ctl !== 5'b01101 || done_status !== 2'b01 || done_pix_cnt !== 17'd0) begin
      errors++; $display("FAIL expiry_finish_report: got ctl=%b st=%b cnt=%0d want 01101/01/0",
                         ctl, done_status, done_pix_cnt);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    cmd_valid = 1'b1; cmd_mode = 2'd2;
    step();
    cmd_valid = 1'b0;
    step(); step();                            // +3 RUN
    ipf_valid = 1'b1;
    step(); step();                            // +5, two pixels counted
    ipf_valid = 1'b0;
    checks++;
    if (ctl !== 5'b01010 || done_pix_cnt !== 17'd2) begin
      errors++; $display("FAIL midrun_pre: got ctl=%b cnt=%0d want 01010/2", ctl, done_pix_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b10100 || done_pix_cnt !== 17'd0 || ipf_mode !== 2'd0 || done_status !== 2'b00) begin
      errors++; $display("FAIL midrun_async: got ctl=%b cnt=%0d mode=%0d st=%b want 10100/0/0/00",
                         ctl, done_pix_cnt, ipf_mode, done_status);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ctl !== 5'b10100) begin errors++; $display("FAIL midrun_after[%0d]: got %b want %b", i, ctl, 5'b10100); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal_job();
    test_mismatch();
    test_illegal_backpressure();
    test_timeout();
    test_finish_at_expiry();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
